// File: rtl/dong_ho_param.sv
// Parameterised BCD wall clock: prescaler, HH:MM:SS cascade (24h or 12h with pm),
// validated time-set handshake (IDLE/CHECK/LOAD) and an hour:minute alarm latch.
module dong_ho_param #(
  parameter int unsigned CLK_DIV = 50000000,
  parameter int unsigned H12     = 0
) (
  input  logic       clki,
  input  logic       rs,
  input  logic       run,
  input  logic       set_valid,
  input  logic [7:0] set_hh,
  input  logic [7:0] set_mm,
  input  logic [7:0] set_ss,
  output logic       set_ready,
  output logic       set_err,
  input  logic       alarm_en,
  input  logic [7:0] alarm_hh,
  input  logic [7:0] alarm_mm,
  input  logic       alarm_ack,
  output logic [3:0] led1,
  output logic [3:0] led2,
  output logic [3:0] led3,
  output logic [3:0] led4,
  output logic [3:0] led5,
  output logic [3:0] led6,
  output logic       pm,
  output logic       sec_tick,
  output logic       alarm_out
);

  localparam int unsigned     PW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0]   PresMax = PW'(CLK_DIV - 1);
  // 12-hour clocks come out of reset showing 12:00:00
  localparam logic [3:0]      RstHt   = (H12 != 0) ? 4'd1 : 4'd0;
  localparam logic [3:0]      RstHu   = (H12 != 0) ? 4'd2 : 4'd0;

  typedef enum logic [1:0] {StIdle, StCheck, StLoad} set_st_e;

  set_st_e       st_q, st_d;
  logic [7:0]    hold_hh_q, hold_hh_d;
  logic [7:0]    hold_mm_q, hold_mm_d;
  logic [7:0]    hold_ss_q, hold_ss_d;
  logic          set_err_q, set_err_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    h_t_q, h_t_d, h_u_q, h_u_d;
  logic [3:0]    m_t_q, m_t_d, m_u_q, m_u_d;
  logic [3:0]    s_t_q, s_t_d, s_u_q, s_u_d;
  logic          pm_q, pm_d;
  logic          alarm_q, alarm_d;

  logic          load_en;
  logic          check_bad;
  logic          set_ok;
  logic          tick;
  logic          alarm_match;
  logic          sec_carry, min_carry;
  logic [3:0]    inc_ht, inc_hu, inc_mt, inc_mu, inc_st, inc_su;
  logic          inc_pm;

  function automatic logic bcd_ok(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  // Validate the held set request; BCD compares are plain binary once nibbles are legal
  always_comb begin
    logic hh_ok;
    if (H12 != 0) begin
      hh_ok = (hold_hh_q >= 8'h01) && (hold_hh_q <= 8'h12);
    end else begin
      hh_ok = (hold_hh_q <= 8'h23);
    end
    set_ok = bcd_ok(hold_hh_q) && bcd_ok(hold_mm_q) && bcd_ok(hold_ss_q) &&
             (hold_mm_q <= 8'h59) && (hold_ss_q <= 8'h59) && hh_ok;
  end

  // Set FSM: state register
  always_ff @(posedge clki or negedge rs) begin
    if (!rs) begin
      st_q <= StIdle;
    end else begin
      st_q <= st_d;
    end
  end

  // Set FSM: next-state logic
  always_comb begin
    st_d = st_q;
    unique case (st_q)
      StIdle:  if (set_valid) st_d = StCheck;
      StCheck: st_d = set_ok ? StLoad : StIdle;
      StLoad:  st_d = StIdle;
      default: st_d = StIdle;
    endcase
  end

  // Set FSM: outputs
  always_comb begin
    set_ready = (st_q == StIdle);
    load_en   = (st_q == StLoad);
    check_bad = (st_q == StCheck) && !set_ok;
  end

  // Capture request only on the IDLE handshake; error pulse lands the cycle after CHECK
  always_comb begin
    hold_hh_d = hold_hh_q;
    hold_mm_d = hold_mm_q;
    hold_ss_d = hold_ss_q;
    if ((st_q == StIdle) && set_valid) begin
      hold_hh_d = set_hh;
      hold_mm_d = set_mm;
      hold_ss_d = set_ss;
    end
    set_err_d = check_bad;
  end

  // Holding registers and error pulse
  always_ff @(posedge clki or negedge rs) begin
    if (!rs) begin
      hold_hh_q <= 8'h00;
      hold_mm_q <= 8'h00;
      hold_ss_q <= 8'h00;
      set_err_q <= 1'b0;
    end else begin
      hold_hh_q <= hold_hh_d;
      hold_mm_q <= hold_mm_d;
      hold_ss_q <= hold_ss_d;
      set_err_q <= set_err_d;
    end
  end

  // Second tick; a tick landing on LOAD is dropped so the loaded time wins
  always_comb begin
    tick = run && (presc_q == PresMax) && !load_en;
    if (load_en) begin
      presc_d = '0;
    end else if (run) begin
      presc_d = (presc_q == PresMax) ? '0 : presc_q + PW'(1);
    end else begin
      presc_d = presc_q;
    end
  end

  // Prescaler register
  always_ff @(posedge clki or negedge rs) begin
    if (!rs) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  // Incremented time: seconds -> minutes -> hours BCD cascade
  always_comb begin
    inc_ht    = h_t_q;
    inc_hu    = h_u_q;
    inc_mt    = m_t_q;
    inc_mu    = m_u_q;
    inc_st    = s_t_q;
    inc_su    = s_u_q;
    inc_pm    = pm_q;
    sec_carry = 1'b0;
    min_carry = 1'b0;

    if (s_u_q == 4'd9) begin
      inc_su = 4'd0;
      if (s_t_q == 4'd5) begin
        inc_st    = 4'd0;
        sec_carry = 1'b1;
      end else begin
        inc_st = s_t_q + 4'd1;
      end
    end else begin
      inc_su = s_u_q + 4'd1;
    end

    if (sec_carry) begin
      if (m_u_q == 4'd9) begin
        inc_mu = 4'd0;
        if (m_t_q == 4'd5) begin
          inc_mt    = 4'd0;
          min_carry = 1'b1;
        end else begin
          inc_mt = m_t_q + 4'd1;
        end
      end else begin
        inc_mu = m_u_q + 4'd1;
      end
    end

    if (min_carry) begin
      if (H12 != 0) begin
        if ((h_t_q == 4'd1) && (h_u_q == 4'd2)) begin
          inc_ht = 4'd0;
          inc_hu = 4'd1;
        end else if ((h_t_q == 4'd1) && (h_u_q == 4'd1)) begin
          // 11 -> 12 is where the half-day flips
          inc_ht = 4'd1;
          inc_hu = 4'd2;
          inc_pm = ~pm_q;
        end else if (h_u_q == 4'd9) begin
          inc_ht = h_t_q + 4'd1;
          inc_hu = 4'd0;
        end else begin
          inc_hu = h_u_q + 4'd1;
        end
      end else begin
        if ((h_t_q == 4'd2) && (h_u_q == 4'd3)) begin
          inc_ht = 4'd0;
          inc_hu = 4'd0;
        end else if (h_u_q == 4'd9) begin
          inc_ht = h_t_q + 4'd1;
          inc_hu = 4'd0;
        end else begin
          inc_hu = h_u_q + 4'd1;
        end
      end
    end
  end

  // Digit next-state: LOAD beats tick beats hold
  always_comb begin
    h_t_d = h_t_q;
    h_u_d = h_u_q;
    m_t_d = m_t_q;
    m_u_d = m_u_q;
    s_t_d = s_t_q;
    s_u_d = s_u_q;
    pm_d  = pm_q;
    if (load_en) begin
      {h_t_d, h_u_d} = hold_hh_q;
      {m_t_d, m_u_d} = hold_mm_q;
      {s_t_d, s_u_d} = hold_ss_q;
    end else if (tick) begin
      h_t_d = inc_ht;
      h_u_d = inc_hu;
      m_t_d = inc_mt;
      m_u_d = inc_mu;
      s_t_d = inc_st;
      s_u_d = inc_su;
      pm_d  = inc_pm;
    end
  end

  // Time digit and pm registers
  always_ff @(posedge clki or negedge rs) begin
    if (!rs) begin
      h_t_q <= RstHt;
      h_u_q <= RstHu;
      m_t_q <= 4'd0;
      m_u_q <= 4'd0;
      s_t_q <= 4'd0;
      s_u_q <= 4'd0;
      pm_q  <= 1'b0;
    end else begin
      h_t_q <= h_t_d;
      h_u_q <= h_u_d;
      m_t_q <= m_t_d;
      m_u_q <= m_u_d;
      s_t_q <= s_t_d;
      s_u_q <= s_u_d;
      pm_q  <= pm_d;
    end
  end

  // Alarm: only a tick can raise it; a raise beats a same-cycle ack
  always_comb begin
    alarm_match = tick && alarm_en &&
                  ({inc_ht, inc_hu} == alarm_hh) && ({inc_mt, inc_mu} == alarm_mm) &&
                  (inc_st == 4'd0) && (inc_su == 4'd0);
    if (alarm_match) begin
      alarm_d = 1'b1;
    end else if (alarm_ack || !alarm_en) begin
      alarm_d = 1'b0;
    end else begin
      alarm_d = alarm_q;
    end
  end

  // Alarm latch
  always_ff @(posedge clki or negedge rs) begin
    if (!rs) begin
      alarm_q <= 1'b0;
    end else begin
      alarm_q <= alarm_d;
    end
  end

  assign set_err   = set_err_q;
  assign sec_tick  = tick;
  assign alarm_out = alarm_q;
  assign pm        = pm_q;
  assign led1      = h_t_q;
  assign led2      = h_u_q;
  assign led3      = m_t_q;
  assign led4      = m_u_q;
  assign led5      = s_t_q;
  assign led6      = s_u_q;

endmodule

// File: doc/dong_ho_param.md
DONG_HO_PARAM -- requirements
Module: dong_ho_param

Interface
REQ-001 Parameter CLK_DIV, default 50000000: clki cycles per one-second tick; legal range >= 2.
REQ-002 Parameter H12, default 0: 0 = 24-hour mode, 1 = 12-hour mode with AM/PM flag.
REQ-003 Port clki, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-004 Port rs, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port run, input, 1 bit: 1 = time advances; 0 = time frozen with the prescaler held.
REQ-006 Set-time ports:
- set_valid, input, 1 bit: load request.
- set_hh, set_mm, set_ss, inputs, 8 bits each: packed BCD, {tens, units}.
REQ-007 Port set_ready, output, 1 bit: 1 when a load can be accepted.
REQ-008 Port set_err, output, 1 bit: one-cycle pulse when a load request is rejected.
REQ-009 Alarm input ports:
- alarm_en, input, 1 bit: alarm enable.
- alarm_hh, alarm_mm, inputs, 8 bits each: alarm time, packed BCD.
- alarm_ack, input, 1 bit: clears alarm_out.
REQ-010 Digit outputs, output, 4 bits each, BCD: led1/led2 = hour tens/units, led3/led4 = minute tens/units, led5/led6 = second tens/units.
REQ-011 Status outputs:
- pm, output, 1 bit: PM flag; always 0 when H12 = 0.
- sec_tick, output, 1 bit: one-cycle pulse on each second increment.
- alarm_out, output, 1 bit: latched alarm indication.

Function
REQ-012 Prescaler behaviour:
- Width is clog2(CLK_DIV).
- Counts 0..CLK_DIV-1 while run = 1 and wraps to 0.
- sec_tick asserts in the cycle the prescaler equals CLK_DIV-1; the time digits advance on that same edge.
REQ-013 When run = 0: prescaler holds its value, digits hold, sec_tick = 0.
REQ-014 BCD cascade:
- Seconds 59 -> 00 carries into minutes.
- Minutes 59 -> 00 carries into hours.
- Every digit stays in the range 0..9; tens digits are limited to 0..5 for minutes and seconds.
REQ-015 H12 = 0: hours count 00..23; 23:59:59 -> 00:00:00.
REQ-016 H12 = 1 hour sequence:
- Hours count 12, 01..11; 12:59:59 -> 01:00:00.
- 11:59:59 -> 12:00:00 toggles pm.
REQ-017 Set FSM has three states: IDLE, CHECK, LOAD.
- set_ready = 1 only in IDLE.
- IDLE: set_valid = 1 captures set_hh/mm/ss into holding registers and moves to CHECK.
REQ-018 CHECK (1 cycle) validation:
- Every nibble must be <= 9; mm and ss must be <= 59.
- hh must be <= 23 in 24-hour mode, or 01..12 in 12-hour mode.
- Valid goes to LOAD; invalid pulses set_err for 1 cycle and returns to IDLE.
REQ-019 LOAD (1 cycle):
- Writes the held time into the digits and clears the prescaler to 0; pm is unchanged.
- Returns to IDLE.
- A sec_tick coinciding with LOAD is discarded; the loaded value wins.
REQ-020 Held values come only from the IDLE capture; set_* changes after capture have no effect.
REQ-021 Alarm match:
- On a sec_tick edge where the new time equals alarm_hh:alarm_mm:00 and alarm_en = 1, alarm_out sets to 1.
- H12 = 1 compares hours only, ignoring pm.
REQ-022 alarm_out stays 1 until alarm_ack = 1 or alarm_en = 0, then clears on the next edge.
- If a match and alarm_ack occur in the same cycle, the match wins.
REQ-023 A time loaded via LOAD that equals the alarm time does not set alarm_out; only a tick-driven match does.
REQ-024 The implementation is synchronous to clki except for the rs reset path; it contains no combinational loops.

Reset
REQ-025 When rs = 0, all state clears asynchronously:
- prescaler = 0; FSM = IDLE; sec_tick = 0; set_err = 0; alarm_out = 0; pm = 0.
- Digits = 00:00:00 when H12 = 0, or 12:00:00 when H12 = 1.
REQ-026 set_ready = 1 while rs = 0 and after rs rises.
- The first increment happens CLK_DIV cycles after the first edge with rs = 1 and run = 1.
REQ-027 rs asserted mid-LOAD or mid-CHECK aborts the load; digits take their reset values.

Verification (CLK_DIV = 4)
REQ-028 Reset then run = 1: sec_tick pulses every 4 cycles, and the digits read 00:00:01 after the 4th edge.
REQ-029 H12 = 0 wrap: load 23:59:59, one tick -> led1..led6 = 0,0,0,0,0,0.
REQ-030 H12 = 1, pm = 0:
- Load 11:59:59, one tick -> 12:00:00 with pm = 1.
- Load 12:59:59, one tick -> 01:00:00 with pm = 1 unchanged.
REQ-031 Reject cases:
- set_mm = 8'h60 -> set_err pulse 2 cycles after the handshake; digits unchanged.
- set_ss = 8'h1A -> same response.
REQ-032 Alarm sequence:
- alarm 00:01, alarm_en = 1, load 00:00:59, one tick -> alarm_out = 1.
- alarm_ack -> alarm_out = 0 on the next edge.
REQ-033 Run and prescaler:
- run = 0 for 10 cycles -> digits and prescaler frozen.
- LOAD arriving with the prescaler at 3 -> prescaler = 0 and no increment that cycle.
